// File: rtl/glitc_debug_sel_ctrl.sv
// Select control for the GLITC debug mux: fixed or round-robin source selection,
// with a settle-qualified valid flag so capture ignores the cycles after each switch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SETTLE  | sel_o recently changed; mux output not yet trusted, valid_o=0
// DWELL   | sel_o stable and settled; in auto mode the dwell timer runs
module glitc_debug_sel_ctrl #(
    parameter int DWELL_WIDTH = 16,
    parameter int SETTLE      = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_wr_i,
    input  logic [31:0] cfg_dat_i,
    input  logic        hold_i,
    output logic [1:0]  sel_o,
    output logic        valid_o,
    output logic        switch_o,
    output logic [3:0]  status_o
);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_DWELL  = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t                  state_q, state_d;
    logic [3:0]              settle_q, settle_d;
    logic [DWELL_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;
    logic                    auto_q, auto_d;
    logic [3:0]              mask_q, mask_d;
    logic [1:0]              sel_q, sel_d;
    logic                    valid_q, valid_d;
    logic                    switch_q, switch_d;

    logic [1:0]              wr_start;
    logic                    wr_auto;
    logic [3:0]              wr_mask;
    logic [DWELL_WIDTH-1:0]  wr_dwell;
    logic [1:0]              wr_target;
    logic [2:0]              rot_nxt;
    logic [2:0]              wr_nxt;
    logic                    do_settle;
    logic                    unused_cfg;

    // Returns {found, index} of the first enabled source strictly after 'from'.
    function automatic logic [2:0] next_after(input logic [3:0] mask, input logic [1:0] from);
        logic [2:0] r;
        logic [1:0] idx;
        r = {1'b0, from};
        for (int k = 3; k >= 1; k--) begin
            idx = from + 2'(k);
            if (mask[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    // The dwell timer is a down-counter; a dwell of 0 behaves like 1.
    function automatic logic [DWELL_WIDTH-1:0] term_of(input logic [DWELL_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
    endfunction

    assign wr_start   = cfg_dat_i[1:0];
    assign wr_auto    = cfg_dat_i[2];
    assign wr_mask    = cfg_dat_i[7:4];
    assign wr_dwell   = cfg_dat_i[16+DWELL_WIDTH-1:16];
    assign unused_cfg = &{1'b0, cfg_dat_i};

    assign rot_nxt = next_after(mask_q, sel_q);
    assign wr_nxt  = next_after(wr_mask, wr_start);

    always_comb begin
        wr_target = wr_start;
        if (wr_auto) begin
            if (wr_mask == 4'b0000) begin
                wr_target = sel_q;
            end else if (!wr_mask[wr_start]) begin
                wr_target = wr_nxt[1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        dcnt_d    = dcnt_q;
        dwell_d   = dwell_q;
        auto_d    = auto_q;
        mask_d    = mask_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        switch_d  = 1'b0;
        do_settle = 1'b0;

        if (cfg_wr_i) begin
            // A write always wins over a rotation due on the same edge.
            auto_d  = wr_auto;
            mask_d  = wr_mask;
            dwell_d = wr_dwell;
            if (wr_target != sel_q) begin
                sel_d    = wr_target;
                switch_d = 1'b1;
                valid_d  = 1'b0;
                state_d  = ST_SETTLE;
                settle_d = SETTLE_LD;
            end else if (state_q == ST_DWELL) begin
                dcnt_d = term_of(wr_dwell);
            end else begin
                do_settle = 1'b1;
            end
        end else if (state_q == ST_SETTLE) begin
            do_settle = 1'b1;
        end else if (auto_q) begin
            if (dcnt_q != '0) begin
                dcnt_d = dcnt_q - DWELL_WIDTH'(1);
            end else if (!hold_i) begin
                if (rot_nxt[2]) begin
                    sel_d    = rot_nxt[1:0];
                    switch_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LD;
                end else begin
                    dcnt_d = term_of(dwell_q);
                end
            end
        end

        // Entering DWELL loads the timer from the dwell in force after this edge.
        if (do_settle) begin
            if (settle_q <= 4'd1) begin
                state_d = ST_DWELL;
                valid_d = 1'b1;
                dcnt_d  = term_of(dwell_d);
            end else begin
                settle_d = settle_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_LD;
            dcnt_q   <= '0;
            dwell_q  <= '0;
            auto_q   <= 1'b0;
            mask_q   <= 4'b0001;
            sel_q    <= 2'd0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            dcnt_q   <= dcnt_d;
            dwell_q  <= dwell_d;
            auto_q   <= auto_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign sel_o    = sel_q;
    assign valid_o  = valid_q;
    assign switch_o = switch_q;
    assign status_o = {valid_q, auto_q, sel_q};

endmodule

// File: tb/tb_glitc_debug_sel_ctrl.sv
// Bench for glitc_debug_sel_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model.
module tb_glitc_debug_sel_ctrl;

    localparam int DW = 16;
    localparam int ST = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cfg_wr_i;
    logic [31:0] cfg_dat_i;
    logic        hold_i;
    logic [1:0]  sel_o;
    logic        valid_o;
    logic        switch_o;
    logic [3:0]  status_o;

    glitc_debug_sel_ctrl #(.DWELL_WIDTH(DW), .SETTLE(ST)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .cfg_wr_i (cfg_wr_i),
        .cfg_dat_i(cfg_dat_i),
        .hold_i   (hold_i),
        .sel_o    (sel_o),
        .valid_o  (valid_o),
        .switch_o (switch_o),
        .status_o (status_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: sources as integers, settle as cycles-left, dwell as elapsed cycles.
    logic [1:0] m_sel;
    logic       m_valid, m_switch, m_auto;
    logic [3:0] m_mask;
    int         m_dwell, m_left, m_dcnt;
    bit         m_settling;

    function automatic int next_src(input logic [3:0] mask, input int from);
        for (int k = 1; k <= 3; k++) begin
            if (mask[2'((from + k) % 4)]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic int term_m();
        return ((m_dwell > 1) ? m_dwell : 1) - 1;
    endfunction

    task automatic model_reset();
        m_sel = 2'd0; m_valid = 1'b0; m_switch = 1'b0; m_auto = 1'b0;
        m_mask = 4'b0001; m_dwell = 0; m_settling = 1'b1; m_left = ST; m_dcnt = 0;
    endtask

    task automatic start_visit(input int t);
        m_sel = 2'(t); m_switch = 1'b1; m_valid = 1'b0; m_settling = 1'b1; m_left = ST;
    endtask

    task automatic settle_tick();
        m_left--;
        if (m_left == 0) begin
            m_settling = 1'b0; m_valid = 1'b1; m_dcnt = 0;
        end
    endtask

    task automatic model_step(input logic wr, input logic [31:0] dat, input logic hold);
        int tgt, nx;
        m_switch = 1'b0;
        if (wr) begin
            m_auto = dat[2]; m_mask = dat[7:4]; m_dwell = int'(dat[31:16]);
            tgt = int'(dat[1:0]);
            if (m_auto) begin
                if (m_mask == 4'b0000) tgt = int'(m_sel);
                else if (!m_mask[dat[1:0]]) tgt = next_src(m_mask, tgt);
            end
            if (tgt != int'(m_sel)) start_visit(tgt);
            else if (!m_settling) m_dcnt = 0;
            else settle_tick();
        end else if (m_settling) begin
            settle_tick();
        end else if (m_auto) begin
            if (m_dcnt < term_m()) m_dcnt++;
            else if (!hold) begin
                nx = next_src(m_mask, int'(m_sel));
                if (nx >= 0) start_visit(nx);
                else m_dcnt = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".sel"},    32'(sel_o),    32'(m_sel));
        chk({tag, ".valid"},  32'(valid_o),  32'(m_valid));
        chk({tag, ".switch"}, 32'(switch_o), 32'(m_switch));
        chk({tag, ".status"}, 32'(status_o), 32'({m_valid, m_auto, m_sel}));
        chk({tag, ".excl"},   32'(switch_o & valid_o), 32'(0));
    endtask

    task automatic cycle(input logic wr, input logic [31:0] dat, input logic hold);
        cfg_wr_i  = wr;
        cfg_dat_i = dat;
        hold_i    = hold;
        @(posedge clk_i);
        model_step(wr, dat, hold);
        #1;
        compare_all("cyc");
        cfg_wr_i = 1'b0;
    endtask

    task automatic do_reset();
        cfg_wr_i = 1'b0;
        rst_n_i  = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        chk("rst_async.status0", 32'(status_o), 32'(0));
        @(posedge clk_i);
        #1;
        compare_all("rst_held");
        rst_n_i = 1'b1;
    endtask

    function automatic logic [31:0] mk_cfg(input int dwell, input logic [3:0] mask,
                                          input logic auto_m, input logic [1:0] start);
        return {16'(dwell), 8'h00, mask, 1'b0, auto_m, start};
    endfunction

    int         sw_cyc[$];
    logic [1:0] sw_sel[$];
    int         vcnt[$];
    int         vrun;
    bit         found;
    logic [1:0] x_tgt;
    logic       hold_st;
    logic       wr_r;
    logic [31:0] dat_r;
    logic [1:0] exp_seq [5];

    initial begin
        rst_n_i = 1'b1; cfg_wr_i = 1'b0; cfg_dat_i = '0; hold_i = 1'b0;
        #1;
        do_reset();

        // Release: valid exactly SETTLE edges later.
        cycle(1'b0, '0, 1'b0);
        chk("rel.e1.valid", 32'(valid_o), 32'(0));
        cycle(1'b0, '0, 1'b0);
        chk("rel.e2.valid", 32'(valid_o), 32'(1));
        chk("rel.e2.sel", 32'(sel_o), 32'(0));

        // Fixed write and identical rewrite.
        cycle(1'b1, 32'h0000_0003, 1'b0);
        chk("fix.sel", 32'(sel_o), 32'(3));
        chk("fix.switch", 32'(switch_o), 32'(1));
        cycle(1'b0, '0, 1'b0);
        chk("fix.sw_off", 32'(switch_o), 32'(0));
        chk("fix.v0", 32'(valid_o), 32'(0));
        cycle(1'b0, '0, 1'b0);
        chk("fix.v1", 32'(valid_o), 32'(1));
        cycle(1'b1, 32'h0000_0003, 1'b0);
        chk("fix.rw.switch", 32'(switch_o), 32'(0));
        chk("fix.rw.valid", 32'(valid_o), 32'(1));

        // Auto rotation 0,1,3,0,1 with 6-cycle visits, 4 valid cycles each.
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        vrun = 0;
        for (int i = 0; i < 30; i++) begin
            cycle((i == 0), mk_cfg(4, 4'b1011, 1'b1, 2'd0), 1'b0);
            if (switch_o) begin
                sw_cyc.push_back(i);
                sw_sel.push_back(sel_o);
                if (i != 0) vcnt.push_back(vrun);
                vrun = 0;
            end
            if (valid_o) vrun++;
        end
        chk("rot.count", 32'(sw_cyc.size()), 32'(5));
        for (int i = 0; i < 5 && i < sw_cyc.size(); i++) begin
            chk("rot.sel", 32'(sw_sel[i]), 32'(exp_seq[i]));
            chk("rot.gap", 32'(sw_cyc[i]), 32'(6 * i));
        end
        for (int i = 0; i < vcnt.size(); i++) chk("rot.vhigh", 32'(vcnt[i]), 32'(4));

        // Hold across terminal: frozen, then switch on first release cycle.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("hold.switch", 32'(switch_o), 32'(0));
            chk("hold.valid", 32'(valid_o), 32'(1));
        end
        cycle(1'b0, '0, 1'b0);
        chk("hold.release.switch", 32'(switch_o), 32'(1));
        chk("hold.release.sel", 32'(sel_o), 32'(3));

        // Mask edge cases.
        cycle(1'b1, mk_cfg(1, 4'b0000, 1'b1, 2'd2), 1'b0);
        chk("m0.switch", 32'(switch_o), 32'(0));
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("m0.noswitch", 32'(switch_o), 32'(0));
        end
        cycle(1'b1, mk_cfg(1, 4'b0001, 1'b1, 2'd2), 1'b0);
        chk("m1.sel", 32'(sel_o), 32'(0));
        chk("m1.switch", 32'(switch_o), 32'(1));
        cycle(1'b1, mk_cfg(1, 4'b0010, 1'b1, 2'd1), 1'b0);
        chk("m2.sel", 32'(sel_o), 32'(1));
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("m2.noswitch", 32'(switch_o), 32'(0));
        end

        // Write colliding with an auto terminal.
        cycle(1'b1, mk_cfg(3, 4'b1111, 1'b1, 2'd1), 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!m_settling && m_auto && m_dcnt == term_m()) found = 1'b1;
            else cycle(1'b0, '0, 1'b0);
        end
        chk("coll.reach_terminal", 32'(found), 32'(1));
        x_tgt = m_sel + 2'd2;
        cycle(1'b1, mk_cfg(0, 4'b0000, 1'b0, x_tgt), 1'b0);
        chk("coll.sel", 32'(sel_o), 32'(x_tgt));
        chk("coll.switch", 32'(switch_o), 32'(1));

        // Reset asserted mid-settle, then release timing again.
        do_reset();
        cycle(1'b0, '0, 1'b0);
        chk("rel2.e1.valid", 32'(valid_o), 32'(0));
        cycle(1'b0, '0, 1'b0);
        chk("rel2.e2.valid", 32'(valid_o), 32'(1));

        // Random traffic.
        hold_st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            wr_r  = ($urandom_range(0, 11) == 0);
            dat_r = $urandom;
            dat_r[31:16] = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 2) != 0) dat_r[2] = 1'b1;
            if ($urandom_range(0, 9) == 0) hold_st = ~hold_st;
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle(wr_r, dat_r, hold_st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glitc_debug_sel_ctrl.md
# glitc_debug_sel_ctrl

Controls the select input of the GLITC debug mux, which chooses one of four 71-bit debug buses. The block supports two modes: a fixed source written by software, or automatic round-robin rotation over an enabled subset of sources with a programmable dwell. After every select change it deasserts a settle-qualified valid flag so the downstream capture logic ignores the transition cycles. It sits between the register interface and the debug mux, and also talks to the capture engine through `hold_i` and `valid_o`.

## Interface
- `DWELL_WIDTH`, default 16: width of the dwell counter and of the dwell config field (maximum 16).
- `SETTLE`, default 2: cycles from a `sel_o` change to `valid_o` reassertion. Legal range is 1..15. The default covers the mux register plus one downstream stage.
- `clk_i`  in  1: the single clock. The debug mux uses the same clock.
- `rst_n_i`  in  1: reset, asynchronous and active-low.
- `cfg_wr_i`  in  1: one-cycle config write strobe.
- `cfg_dat_i`  in  32: config word, sampled when `cfg_wr_i` is high.
  - [1:0] is the fixed/start select.
  - [2] is auto mode.
  - [7:4] is the enable mask.
  - [16+DWELL_WIDTH-1:16] is the dwell.
- `hold_i`  in  1: capture in progress; high freezes rotation.
- `sel_o`  out  2: drives the debug mux `sel_i`.
- `valid_o`  out  1: the mux output reflects `sel_o` and has settled.
- `switch_o`  out  1: one-cycle pulse in the first cycle a new `sel_o` value is presented.
- `status_o`  out  4: `{valid_o, auto, sel_o}`.

## Operation
- **Reset values.**
  - Outputs: `sel_o`=0, `valid_o`=0, `switch_o`=0, `status_o`=0.
  - Config: auto=0, mask=4'b0001, dwell=0.
  - FSM enters SETTLE with the settle counter at SETTLE.
- **FSM states:** SETTLE and DWELL.
- **SETTLE.**
  - The counter decrements once per cycle.
  - On the edge where it would reach 0, the FSM enters DWELL, `valid_o` goes to 1 and the dwell counter clears.
- **DWELL.**
  - In fixed mode the FSM stays in DWELL and the dwell counter is idle.
  - In auto mode the dwell counter increments each cycle and saturates at its terminal value, which is max(dwell,1)−1. A dwell of 0 is treated as 1.
  - At terminal with `hold_i`=0, the block selects the next source: the first enabled source strictly after `sel_o` in the order sel+1, sel+2, sel+3 (mod 4).
  - If such a source exists and differs from `sel_o`, the block updates `sel_o`, pulses `switch_o`, clears `valid_o` and enters SETTLE.
  - If no other source is enabled (mask 0, or only the current source), `sel_o` is unchanged, the dwell counter clears and `valid_o` stays 1.
  - At terminal with `hold_i`=1, the counter holds at terminal. The switch happens on the first cycle `hold_i` is 0.
- **Config write** (registered on the edge where `cfg_wr_i`=1). The target is computed as follows:
  - Fixed mode: target = cfg[1:0].
  - Auto mode: target = cfg[1:0] if that source is enabled in the new mask. Otherwise target = the next enabled source after it. If the new mask is 0, target = the current `sel_o`.
  - If the target differs from `sel_o`: `sel_o` takes the target, `switch_o` pulses, `valid_o`=0, and the FSM enters SETTLE with the counter reloaded.
  - If the target equals `sel_o` and the FSM is in DWELL: no switch, `valid_o` is unchanged, and the dwell counter clears.
  - If the target equals `sel_o` and the FSM is in SETTLE: the settle count continues without a reload.
- **Write priority.** A write takes priority over a simultaneous auto-rotation on the same edge. `hold_i` never blocks a write.
- **Reset mid-operation.** Asserting `rst_n_i` at any point returns everything to the reset values immediately, with no clock required.

## Timing
- Write sampled at edge N:
  - `sel_o`, `switch_o`=1 and `valid_o`=0 appear after edge N.
  - `switch_o` returns to 0 after edge N+1.
  - The debug mux output carries the new source after edge N+1.
  - `valid_o`=1 after edge N+SETTLE.
- Auto mode, in steady state:
  - One source occupies SETTLE+max(dwell,1) cycles per visit.
  - `valid_o` is high for max(dwell,1) of those cycles.
- `switch_o` and `valid_o` are never both 1.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
- **Reset.** Assert `rst_n_i` with no clock → outputs are 0. Release it → `valid_o`=1 exactly SETTLE(2) edges later with `sel_o`=0.
- **Fixed write.** Write cfg=0x0000_0003 → `sel_o`=3 and a 1-cycle `switch_o` after the write edge; `valid_o` is 0 for 2 cycles, then 1. Rewrite the same value → no `switch_o` and no `valid_o` drop.
- **Auto rotation.** Write auto, mask=4'b1011, dwell=4, start 0 → `sel_o` sequence 0,1,3,0,…, each visit 6 cycles with `valid_o` high for 4.
- **Hold.** In auto mode, hold `hold_i`=1 for 20 cycles across the terminal count → `sel_o` is frozen and `valid_o` stays 1. Switch occurs on the first cycle `hold_i`=0.
- **Mask edge cases.** Auto with mask=0 → `sel_o` is unchanged and never switches. Start=2 with mask=4'b0001 → target 0. Start=1 with mask=4'b0010 → single source, no switching.
- **Collision and reset mid-settle.** Issue a write on the same edge as the auto terminal → the write target wins. Assert reset during SETTLE → all outputs return to 0 immediately.
